// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
//   Bundles every signal of the register-file write arbiter except clk/rst_n.
//   master : the surrounding pipeline (WB register, multi-cycle unit, decode)
//            and the register-file side that observes the write port.
//   slave  : the arbiter itself.
//   Groups:
//     WB stage   : wb_valid, wb_is_call, wb_is_ld, wb_rd, wb_alu_result,
//                  wb_ld_result, wb_pc  -> arbiter ; wb_stall <- arbiter
//     Multi-cycle: mc_valid, mc_rd, mc_data -> arbiter ; mc_ready <- arbiter
//     Scoreboard : sb_set, sb_rd -> arbiter ; busy[15:0] <- arbiter
//     RF port    : rf_we, rf_waddr, rf_wdata <- arbiter (registered)
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if;
  logic        wb_valid;
  logic        wb_is_call;
  logic        wb_is_ld;
  logic [3:0]  wb_rd;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_ld_result;
  logic [31:0] wb_pc;
  logic        wb_stall;

  logic        mc_valid;
  logic        mc_ready;
  logic [3:0]  mc_rd;
  logic [31:0] mc_data;

  logic        sb_set;
  logic [3:0]  sb_rd;
  logic [15:0] busy;

  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output wb_valid, wb_is_call, wb_is_ld, wb_rd, wb_alu_result, wb_ld_result, wb_pc,
    output mc_valid, mc_rd, mc_data,
    output sb_set, sb_rd,
    input  wb_stall, mc_ready, busy,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  wb_valid, wb_is_call, wb_is_ld, wb_rd, wb_alu_result, wb_ld_result, wb_pc,
    input  mc_valid, mc_rd, mc_data,
    input  sb_set, sb_rd,
    output wb_stall, mc_ready, busy,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//   Owns the single register-file write port and shares it between the WB
//   stage and the multi-cycle (mul/div) result path. Multi-cycle results are
//   always queued in a DEPTH-entry FIFO and drained whenever WB leaves the
//   port idle. A 16-bit busy scoreboard tracks registers with an outstanding
//   multi-cycle write so decode can stall on them.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     rf     - rf_write_arbiter_if.slave (WB inputs + wb_stall, multi-cycle
//              handshake, scoreboard set/busy, registered RF write port)
//
//   Parameters:
//     DEPTH        - multi-cycle FIFO entries (power of two, >= 2)
//     STARVE_LIMIT - consecutive WB wins with a non-empty FIFO before the FIFO
//                    head is forced onto the port
//
//   Build option:
//     RF_WR_STARVE_GUARD_EN - when defined, adds the starvation counter and a
//     one-cycle FORCE state that grants the FIFO head and stalls WB. When not
//     defined WB has strict priority and wb_stall is tied low.
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  rf_write_arbiter_if.slave rf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } mc_entry_t;

  mc_entry_t        fifo_q [DEPTH];
  mc_entry_t        fifo_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      busy_q, busy_d;
  logic             rf_we_q, rf_we_d;
  logic [3:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;

  logic             fifo_empty;
  logic             fifo_ready;
  logic             push;
  logic             pop;
  logic             wb_win;
  logic             force_grant;
  mc_entry_t        head;

  // Readiness uses the pre-pop count: a full FIFO never passes a result
  // straight through to the port in the same cycle.
  assign fifo_empty = (count_q == '0);
  assign fifo_ready = (count_q < CNT_W'(DEPTH));
  assign push       = rf.mc_valid && fifo_ready;
  assign wb_win     = rf.wb_valid && !force_grant;
  assign pop        = !wb_win && !fifo_empty;
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    busy_d     = busy_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    // Write-port selection; a call overrides a load if both flags are set.
    if (wb_win) begin
      rf_we_d = 1'b1;
      if (rf.wb_is_call) begin
        rf_waddr_d = 4'hF;
        rf_wdata_d = rf.wb_pc + 32'd4;
      end else if (rf.wb_is_ld) begin
        rf_waddr_d = rf.wb_rd;
        rf_wdata_d = rf.wb_ld_result;
      end else begin
        rf_waddr_d = rf.wb_rd;
        rf_wdata_d = rf.wb_alu_result;
      end
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head.rd;
      rf_wdata_d = head.data;
    end

    if (pop) begin
      rd_ptr_d           = rd_ptr_q + PTR_W'(1);
      busy_d[head.rd]    = 1'b0;
    end

    // Applied after the pop clear so a same-cycle set of the same register wins.
    if (rf.sb_set) begin
      busy_d[rf.sb_rd] = 1'b1;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = '{rd: rf.mc_rd, data: rf.mc_data};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Stage boundary: FIFO, scoreboard and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

`ifdef RF_WR_STARVE_GUARD_EN
  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_e;

  localparam int STARVE_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  state_e              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  // Stage boundary: arbitration state and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // The counter only runs while WB keeps beating a waiting FIFO; any pop or
  // an empty FIFO resets it. The win that reaches LIMIT-1 schedules one
  // FORCE cycle in which the FIFO head takes the port and WB holds.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ST_NORMAL: begin
        if (rf.wb_valid && !fifo_empty) begin
          if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
            state_d  = ST_FORCE;
            starve_d = '0;
          end else begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end else begin
          starve_d = '0;
        end
      end
      ST_FORCE: begin
        state_d  = ST_NORMAL;
        starve_d = '0;
      end
      default: begin
        state_d  = ST_NORMAL;
        starve_d = '0;
      end
    endcase
  end

  assign force_grant = (state_q == ST_FORCE);
  assign rf.wb_stall = force_grant;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_grant         = 1'b0;
  assign rf.wb_stall         = 1'b0;
`endif

  assign rf.mc_ready = fifo_ready;
  assign rf.busy     = busy_q;
  assign rf.rf_we    = rf_we_q;
  assign rf.rf_waddr = rf_waddr_q;
  assign rf.rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
//   Directed scenarios plus a randomized run for rf_write_arbiter. Expected
//   values come from constants in the directed tasks and from a queue-based
//   behavioural model for the random run. Follows the RF_WR_STARVE_GUARD_EN
//   build option of the design.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk;
  logic rst_n;

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ------------------------------------------------------------ model state
  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_busy;
  bit          m_force;
  int          m_starve;
  logic        exp_we;
  logic [3:0]  exp_waddr;
  logic [31:0] exp_wdata;

  function automatic void model_reset();
    mq.delete();
    m_busy    = '0;
    m_force   = 1'b0;
    m_starve  = 0;
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endfunction

  // Advance the model by one clock using the inputs currently on the bus.
  function automatic void model_eval();
    ent_t h;
    bit   nonempty, push, wbwin, pop;
    nonempty = (mq.size() > 0);
    push     = bus.mc_valid && (mq.size() < DEPTH);
    wbwin    = bus.wb_valid && !m_force;
    pop      = !wbwin && nonempty;
    exp_we   = wbwin || pop;
    if (wbwin) begin
      if (bus.wb_is_call) begin
        exp_waddr = 4'hF;
        exp_wdata = bus.wb_pc + 32'd4;
      end else if (bus.wb_is_ld) begin
        exp_waddr = bus.wb_rd;
        exp_wdata = bus.wb_ld_result;
      end else begin
        exp_waddr = bus.wb_rd;
        exp_wdata = bus.wb_alu_result;
      end
    end else if (pop) begin
      h         = mq.pop_front();
      exp_waddr = h.rd;
      exp_wdata = h.data;
      m_busy[h.rd] = 1'b0;
    end
    if (bus.sb_set) m_busy[bus.sb_rd] = 1'b1;
    if (push) mq.push_back('{rd: bus.mc_rd, data: bus.mc_data});
`ifdef RF_WR_STARVE_GUARD_EN
    if (m_force) begin
      m_force  = 1'b0;
      m_starve = 0;
    end else if (wbwin && nonempty) begin
      if (m_starve == STARVE_LIMIT - 1) begin
        m_force  = 1'b1;
        m_starve = 0;
      end else begin
        m_starve = m_starve + 1;
      end
    end else begin
      m_starve = 0;
    end
`endif
  endfunction

  // ------------------------------------------------------------ stimulus helpers
  task automatic idle_inputs();
    bus.wb_valid      = 1'b0;
    bus.wb_is_call    = 1'b0;
    bus.wb_is_ld      = 1'b0;
    bus.wb_rd         = '0;
    bus.wb_alu_result = '0;
    bus.wb_ld_result  = '0;
    bus.wb_pc         = '0;
    bus.mc_valid      = 1'b0;
    bus.mc_rd         = '0;
    bus.mc_data       = '0;
    bus.sb_set        = 1'b0;
    bus.sb_rd         = '0;
  endtask

  task automatic drive_wb(input logic v, input logic call, input logic ld, input logic [3:0] rd,
                          input logic [31:0] alu, input logic [31:0] ldr, input logic [31:0] pc);
    bus.wb_valid      = v;
    bus.wb_is_call    = call;
    bus.wb_is_ld      = ld;
    bus.wb_rd         = rd;
    bus.wb_alu_result = alu;
    bus.wb_ld_result  = ldr;
    bus.wb_pc         = pc;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %0b want 0", bus.rf_we); end
    n_tests++; if (bus.rf_waddr !== 4'h0) begin n_fail++; $display("FAIL reset_rf_waddr got %0h want 0", bus.rf_waddr); end
    n_tests++; if (bus.rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_rf_wdata got %08h want 0", bus.rf_wdata); end
    n_tests++; if (bus.busy !== 16'h0) begin n_fail++; $display("FAIL reset_busy got %04h want 0", bus.busy); end
    n_tests++; if (bus.mc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mc_ready got %0b want 1", bus.mc_ready); end
    n_tests++; if (bus.wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_wb_stall got %0b want 0", bus.wb_stall); end
    rst_n = 1'b1;
  endtask

  task automatic test_wb_select();
    drive_wb(1'b1, 1'b0, 1'b0, 4'd3, 32'h0000_1234, 32'h5555_5555, 32'h100);
    tick();
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd3 || bus.rf_wdata !== 32'h0000_1234) begin
      n_fail++; $display("FAIL wb_alu got we=%0b a=%0h d=%08h want we=1 a=3 d=00001234", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end

    drive_wb(1'b1, 1'b0, 1'b1, 4'd5, 32'h1111_1111, 32'hDEAD_BEEF, 32'h104);
    tick();
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd5 || bus.rf_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wb_load got we=%0b a=%0h d=%08h want we=1 a=5 d=deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end

    drive_wb(1'b1, 1'b1, 1'b0, 4'd2, 32'h2222_2222, 32'h3333_3333, 32'hFFFF_FFFC);
    tick();
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'hF || bus.rf_wdata !== 32'h0) begin
      n_fail++; $display("FAIL wb_call got we=%0b a=%0h d=%08h want we=1 a=f d=00000000", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end

    drive_wb(1'b1, 1'b1, 1'b1, 4'd4, 32'h2222_2222, 32'h3333_3333, 32'hFFFF_FFFC);
    tick();
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'hF || bus.rf_wdata !== 32'h0) begin
      n_fail++; $display("FAIL wb_call_ld got we=%0b a=%0h d=%08h want we=1 a=f d=00000000", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end

    drive_wb(1'b1, 1'b1, 1'b0, 4'd4, 32'h0, 32'h0, 32'h0000_1000);
    tick();
    n_tests++; if (bus.rf_wdata !== 32'h0000_1004) begin
      n_fail++; $display("FAIL wb_call_pc4 got d=%08h want 00001004", bus.rf_wdata); end

    idle_inputs();
    tick();
    n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL wb_idle got we=%0b want 0", bus.rf_we); end
  endtask

  task automatic test_fifo_contention();
    logic [3:0]  want_a [3];
    logic [31:0] want_d [3];
    want_a = '{4'd7, 4'd8, 4'd9};
    want_d = '{32'h70, 32'h80, 32'h90};

    // WB holds the port for three cycles while the unit offers 7, 8, 9.
    drive_wb(1'b1, 1'b0, 1'b0, 4'd1, 32'hA0, 32'h0, 32'h0);
    bus.mc_valid = 1'b1; bus.mc_rd = 4'd7; bus.mc_data = 32'h70;
    n_tests++; if (bus.mc_ready !== 1'b1) begin n_fail++; $display("FAIL cont_ready0 got %0b want 1", bus.mc_ready); end
    tick();
    bus.mc_rd = 4'd8; bus.mc_data = 32'h80;
    n_tests++; if (bus.mc_ready !== 1'b1) begin n_fail++; $display("FAIL cont_ready1 got %0b want 1", bus.mc_ready); end
    tick();
    bus.mc_rd = 4'd9; bus.mc_data = 32'h90;
    n_tests++; if (bus.mc_ready !== 1'b0) begin n_fail++; $display("FAIL cont_ready_full got %0b want 0", bus.mc_ready); end
    tick();
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd1) begin
      n_fail++; $display("FAIL cont_wb_owns got we=%0b a=%0h want we=1 a=1", bus.rf_we, bus.rf_waddr); end

    bus.wb_valid = 1'b0;
    n_tests++; if (bus.mc_ready !== 1'b0) begin n_fail++; $display("FAIL cont_ready_prepop got %0b want 0", bus.mc_ready); end
    tick();
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== want_a[0] || bus.rf_wdata !== want_d[0]) begin
      n_fail++; $display("FAIL cont_order0 got we=%0b a=%0h d=%08h want a=%0h d=%08h", bus.rf_we, bus.rf_waddr, bus.rf_wdata, want_a[0], want_d[0]); end
    n_tests++; if (bus.mc_ready !== 1'b1) begin n_fail++; $display("FAIL cont_ready_after_pop got %0b want 1", bus.mc_ready); end
    tick();
    bus.mc_valid = 1'b0;
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== want_a[1] || bus.rf_wdata !== want_d[1]) begin
      n_fail++; $display("FAIL cont_order1 got we=%0b a=%0h d=%08h want a=%0h d=%08h", bus.rf_we, bus.rf_waddr, bus.rf_wdata, want_a[1], want_d[1]); end
    tick();
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== want_a[2] || bus.rf_wdata !== want_d[2]) begin
      n_fail++; $display("FAIL cont_order2 got we=%0b a=%0h d=%08h want a=%0h d=%08h", bus.rf_we, bus.rf_waddr, bus.rf_wdata, want_a[2], want_d[2]); end
    idle_inputs();
    tick();
    n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL cont_drained got we=%0b want 0", bus.rf_we); end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    bus.sb_set = 1'b1; bus.sb_rd = 4'd7;
    bus.mc_valid = 1'b1; bus.mc_rd = 4'd7; bus.mc_data = 32'h71;
    tick();
    n_tests++; if (bus.busy !== 16'h0080) begin n_fail++; $display("FAIL sb_set got %04h want 0080", bus.busy); end
    // Pop of r7 coincides with a fresh set of r7.
    bus.mc_data = 32'h72;
    tick();
    n_tests++; if (bus.busy !== 16'h0080) begin n_fail++; $display("FAIL sb_set_wins got %04h want 0080", bus.busy); end
    n_tests++; if (bus.rf_waddr !== 4'd7 || bus.rf_wdata !== 32'h71) begin
      n_fail++; $display("FAIL sb_pop1 got a=%0h d=%08h want a=7 d=00000071", bus.rf_waddr, bus.rf_wdata); end
    idle_inputs();
    tick();
    n_tests++; if (bus.busy !== 16'h0000) begin n_fail++; $display("FAIL sb_clear got %04h want 0000", bus.busy); end
    n_tests++; if (bus.rf_wdata !== 32'h72) begin n_fail++; $display("FAIL sb_pop2 got d=%08h want 00000072", bus.rf_wdata); end
    tick();
  endtask

  task automatic test_starve_guard();
    drive_wb(1'b1, 1'b0, 1'b0, 4'd2, 32'h2000, 32'h0, 32'h0);
    bus.mc_valid = 1'b1; bus.mc_rd = 4'd10; bus.mc_data = 32'hA0;
    tick();
    bus.mc_valid = 1'b0;
`ifdef RF_WR_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) begin
      bus.wb_alu_result = 32'h2001 + i;
      n_tests++; if (bus.wb_stall !== 1'b0) begin n_fail++; $display("FAIL guard_nostall%0d got %0b want 0", i, bus.wb_stall); end
      tick();
      n_tests++; if (bus.rf_waddr !== 4'd2 || bus.rf_wdata !== 32'h2001 + i) begin
        n_fail++; $display("FAIL guard_wb%0d got a=%0h d=%08h want a=2 d=%08h", i, bus.rf_waddr, bus.rf_wdata, 32'h2001 + i); end
    end
    n_tests++; if (bus.wb_stall !== 1'b1) begin n_fail++; $display("FAIL guard_stall got %0b want 1", bus.wb_stall); end
    tick();
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd10 || bus.rf_wdata !== 32'hA0) begin
      n_fail++; $display("FAIL guard_forced got we=%0b a=%0h d=%08h want a=a d=000000a0", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    n_tests++; if (bus.wb_stall !== 1'b0) begin n_fail++; $display("FAIL guard_stall_1cyc got %0b want 0", bus.wb_stall); end
    tick();
    n_tests++; if (bus.rf_waddr !== 4'd2 || bus.rf_wdata !== 32'h2004) begin
      n_fail++; $display("FAIL guard_wb_resume got a=%0h d=%08h want a=2 d=00002004", bus.rf_waddr, bus.rf_wdata); end
`else
    for (int i = 0; i < 6; i++) begin
      bus.wb_alu_result = 32'h2001 + i;
      n_tests++; if (bus.wb_stall !== 1'b0) begin n_fail++; $display("FAIL noguard_stall%0d got %0b want 0", i, bus.wb_stall); end
      tick();
      n_tests++; if (bus.rf_waddr !== 4'd2 || bus.rf_wdata !== 32'h2001 + i) begin
        n_fail++; $display("FAIL noguard_wb%0d got a=%0h d=%08h want a=2 d=%08h", i, bus.rf_waddr, bus.rf_wdata, 32'h2001 + i); end
    end
    bus.wb_valid = 1'b0;
    tick();
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd10 || bus.rf_wdata !== 32'hA0) begin
      n_fail++; $display("FAIL noguard_fifo got we=%0b a=%0h d=%08h want a=a d=000000a0", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
`endif
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    drive_wb(1'b1, 1'b0, 1'b0, 4'd1, 32'h11, 32'h0, 32'h0);
    bus.sb_set = 1'b1; bus.sb_rd = 4'd6;
    bus.mc_valid = 1'b1; bus.mc_rd = 4'd6; bus.mc_data = 32'h66;
    tick();
    bus.sb_rd = 4'd7; bus.mc_rd = 4'd7; bus.mc_data = 32'h77;
    tick();
    bus.sb_set = 1'b0; bus.mc_valid = 1'b0;
    n_tests++; if (bus.busy !== 16'h00C0) begin n_fail++; $display("FAIL arst_pre_busy got %04h want 00c0", bus.busy); end
    n_tests++; if (bus.mc_ready !== 1'b0) begin n_fail++; $display("FAIL arst_pre_full got %0b want 0", bus.mc_ready); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL arst_rf_we got %0b want 0", bus.rf_we); end
    n_tests++; if (bus.busy !== 16'h0) begin n_fail++; $display("FAIL arst_busy got %04h want 0000", bus.busy); end
    n_tests++; if (bus.mc_ready !== 1'b1) begin n_fail++; $display("FAIL arst_mc_ready got %0b want 1", bus.mc_ready); end
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL arst_stale%0d got we=%0b want 0", i, bus.rf_we); end
    end
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int c = 0; c < 400; c++) begin
      bus.wb_valid      = ($urandom_range(0, 99) < 55);
      bus.wb_is_call    = ($urandom_range(0, 99) < 15);
      bus.wb_is_ld      = ($urandom_range(0, 99) < 35);
      bus.wb_rd         = 4'($urandom_range(0, 15));
      bus.wb_alu_result = $urandom;
      bus.wb_ld_result  = $urandom;
      bus.wb_pc         = $urandom;
      bus.mc_valid      = ($urandom_range(0, 99) < 45);
      bus.mc_rd         = 4'($urandom_range(0, 15));
      bus.mc_data       = $urandom;
      bus.sb_set        = ($urandom_range(0, 99) < 30);
      bus.sb_rd         = 4'($urandom_range(0, 15));
      exp_rdy = (mq.size() < DEPTH);
      n_tests++; if (bus.mc_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c=%0d got %0b want %0b", c, bus.mc_ready, exp_rdy); end
      n_tests++; if (bus.wb_stall !== m_force) begin n_fail++; $display("FAIL rnd_stall c=%0d got %0b want %0b", c, bus.wb_stall, m_force); end
      tick();
      n_tests++; if (bus.rf_we !== exp_we) begin n_fail++; $display("FAIL rnd_we c=%0d got %0b want %0b", c, bus.rf_we, exp_we); end
      if (exp_we) begin
        n_tests++; if (bus.rf_waddr !== exp_waddr || bus.rf_wdata !== exp_wdata) begin
          n_fail++; $display("FAIL rnd_write c=%0d got a=%0h d=%08h want a=%0h d=%08h", c, bus.rf_waddr, bus.rf_wdata, exp_waddr, exp_wdata); end
      end
      n_tests++; if (bus.busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d got %04h want %04h", c, bus.busy, m_busy); end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_wb_select();
    test_fifo_contention();
    test_scoreboard();
    test_starve_guard();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Owns the single register-file write port and shares it between the writeback stage and the multi-cycle unit (mul/div) result path. Performs writeback address/data selection (ALU result, load result, or return address to r15 for calls), buffers multi-cycle results in a small FIFO while WB holds the port, and keeps a 16-bit busy scoreboard so decode can stall on registers with outstanding multi-cycle writes. Sits between the WB pipeline register, the multi-cycle unit and the register file write port.

## Interface
- `DEPTH`, 2, multi-cycle result FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 4, consecutive WB wins with non-empty FIFO before a forced FIFO grant (guard build only)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `wb_valid`  in  1  WB stage holds an instruction with IsWb=1
- `wb_is_call`  in  1  instruction is call
- `wb_is_ld`  in  1  instruction is load
- `wb_rd`  in  4  destination register
- `wb_alu_result`  in  32  ALU result
- `wb_ld_result`  in  32  load data
- `wb_pc`  in  32  PC of the WB instruction
- `wb_stall`  out  1  WB stage must hold its contents this cycle
- `mc_valid`  in  1  multi-cycle result offered
- `mc_ready`  out  1  FIFO accepts a result
- `mc_rd`  in  4  multi-cycle destination
- `mc_data`  in  32  multi-cycle result
- `sb_set`  in  1  decode issued a multi-cycle op this cycle
- `sb_rd`  in  4  its destination register
- `busy`  out  16  per-register outstanding multi-cycle write
- `rf_we`  out  1  register-file write enable (registered)
- `rf_waddr`  out  4  write address (registered)
- `rf_wdata`  out  32  write data (registered)

## Operation
- WB select: call → addr 4'hF, data `wb_pc + 4` (mod 2^32); else load → `wb_rd`, `wb_ld_result`; else `wb_rd`, `wb_alu_result`. `wb_is_call` and `wb_is_ld` both 1 is treated as call.
- FIFO push: `mc_valid && mc_ready`; `mc_ready = (count < DEPTH)`, computed on pre-pop count (no pass-through when full). All multi-cycle results go through the FIFO.
- Grant per cycle, state NORMAL: `wb_valid` → WB wins; else FIFO non-empty → head popped and written; else `rf_we` = 0 next cycle.
- State FORCE (guard build only): FIFO head granted regardless of `wb_valid`; `wb_stall` = 1; WB instruction written on a later cycle.
- Scoreboard: `sb_set` sets `busy[sb_rd]`; a FIFO pop clears `busy[head.rd]`. Same register set and cleared in one cycle → set wins. WB writes never touch `busy`.
- Simultaneous push and pop: count unchanged, order preserved.
- FIFO pointers wrap modulo `DEPTH`.

## Timing
- `rf_we/rf_waddr/rf_wdata` registered: WB instruction at edge N appears at outputs after edge N+1 (1-cycle latency).
- Multi-cycle result accepted at edge N, FIFO empty, no WB → written at outputs after edge N+2.
- `mc_ready` combinational from count; `wb_stall` driven directly from the state register.
- `busy` updates on the edge following `sb_set` / pop.
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `busy`=0, `wb_stall`=0, `mc_ready`=1, state NORMAL, starve counter 0, FIFO empty.
- Reset mid-operation: FIFO contents and scoreboard discarded; write in flight is not performed.

## Configuration
- `RF_WR_STARVE_GUARD_EN` defined: starve counter increments each cycle WB wins while FIFO non-empty. It clears on any FIFO pop or when the FIFO is empty. A WB win with counter = `STARVE_LIMIT-1` moves to FORCE for exactly one cycle, then back to NORMAL with counter 0.
- Not defined: no counter and no FORCE state; `wb_stall` tied 0; WB has strict priority.

## Test plan
- WB ALU: `wb_valid`=1, rd=3, alu=0x1234 → next cycle `rf_we`=1, addr 3, data 0x1234; load rd=5, ld=0xDEAD_BEEF → addr 5, data 0xDEADBEEF.
- Call: `wb_pc`=0xFFFF_FFFC, call=1 → addr 15, data 0x0000_0000 (wrap); call+ld both 1 → same result.
- FIFO contention: hold `wb_valid`=1 for 3 cycles while pushing mc rd=7, rd=8 → `mc_ready`=0 after 2 pushes; the third `mc_valid` is held until `wb_valid` drops; then writes in order 7, 8, third.
- Scoreboard: `sb_set` rd=7 → `busy`=0x0080; pop rd=7 in the same cycle as a new `sb_set` rd=7 → `busy[7]` stays 1; lone pop → `busy`=0.
- Guard (macro on, LIMIT=4): `wb_valid` held, one FIFO entry → 4 WB writes, then `wb_stall`=1 for 1 cycle and a FIFO write; macro off → FIFO waits until `wb_valid`=0, `wb_stall` never 1.
- Async reset asserted with 2 FIFO entries and `busy`=0x00C0 → immediately `rf_we`=0, `busy`=0, `mc_ready`=1; no stale write after release.
